// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI mode-0 responder
// Purpose: SPI mode, default word length and sync depth, and the reset levels
// of the synchronised SPI lines. No ports.
package spi_pkg;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic       c_CPOL     = 1'b0;
    localparam logic       c_CPHA     = 1'b0;
    localparam logic [1:0] c_SPI_MODE = {c_CPOL, c_CPHA};

    localparam int c_DEF_WORD_LEN    = 8;
    localparam int c_DEF_SYNC_STAGES = 2;

    // Synchroniser reset levels: idle bus with the slave deselected.
    localparam logic c_SCLK_RST = c_SPI_MODE[1];
    localparam logic c_MOSI_RST = 1'b0;
    localparam logic c_CS_N_RST = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with rise/fall pulse detection
// Purpose: brings one asynchronous line into the i_clk domain and flags its edges.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   din            : asynchronous input line
//   level          : synchronised level (last sync stage)
//   rise, fall     : one-cycle pulses on a synchronised 0->1 / 1->0 transition
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   p_STAGES  = c_DEF_SYNC_STAGES,
    parameter logic p_RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [p_STAGES-1:0] sync;
    logic                prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync <= {p_STAGES{p_RST_VAL}};
            prev <= p_RST_VAL;
        end else begin
            sync <= {sync[p_STAGES-2:0], din};
            prev <= sync[p_STAGES-1];
        end
    end

    assign level = sync[p_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with host TX load and RX valid pulse
// Purpose: oversamples SCLK/MOSI/CS_N, deserialises MOSI MSB-first into words
// and serialises a host-supplied reply word onto MISO.
// Ports:
//   i_clk, i_rst_n           : system clock, asynchronous active-low reset
//   i_sclk, i_mosi, i_cs_n   : asynchronous SPI inputs from the master
//   o_miso, o_miso_oe        : registered MISO data and its output enable
//   inp_data, inp_en, inp_rdy: TX holding register load handshake
//   out_data, out_valid      : last received word and its one-cycle strobe
//   o_underrun               : pulse when a word starts with nothing to send
module spi_slave
    import spi_pkg::*;
#(
    parameter int p_WORD_LEN    = c_DEF_WORD_LEN,
    parameter int p_SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_mosi,
    input  logic                  i_cs_n,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [p_WORD_LEN-1:0] inp_data,
    input  logic                  inp_en,
    output logic                  inp_rdy,
    output logic [p_WORD_LEN-1:0] out_data,
    output logic                  out_valid,
    output logic                  o_underrun
);

    localparam int                 c_CNT_W = $clog2(p_WORD_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(p_WORD_LEN - 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_n_sync, cs_rise, cs_fall;
    logic mosi_sync;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.p_STAGES(p_SYNC_STAGES), .p_RST_VAL(c_SCLK_RST)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_sclk),
        .level   (sclk_sync),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.p_STAGES(p_SYNC_STAGES), .p_RST_VAL(c_CS_N_RST)) u_sync_cs_n (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_cs_n),
        .level   (cs_n_sync),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync_edge #(.p_STAGES(p_SYNC_STAGES), .p_RST_VAL(c_MOSI_RST)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_mosi),
        .level   (mosi_sync),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    logic [p_WORD_LEN-1:0] hold;
    logic [p_WORD_LEN-1:0] tx_shift;
    logic [p_WORD_LEN-1:0] rx_shift;
    logic [p_WORD_LEN-1:0] rx_next;
    logic [c_CNT_W-1:0]    bit_cnt;
    logic                  word_done;
    logic                  word_start;
    logic                  cs_edge_unused;
    logic                  sclk_level_unused;

    // cs_rise needs no action of its own: cs_n_sync being high already
    // clears the counter and shifters on the same cycle.
    assign cs_edge_unused    = cs_rise;
    assign sclk_level_unused = sclk_sync;

    assign rx_next    = {rx_shift[p_WORD_LEN-2:0], mosi_sync};
    assign word_done  = sclk_rise && !cs_n_sync && (bit_cnt == c_LAST);
    // A cs_fall coinciding with an sclk_rise leaves bit_cnt at 0, so word_done
    // cannot fire then; the rise is still counted below as bit 1.
    assign word_start = cs_fall || word_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_miso     <= 1'b0;
            o_miso_oe  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            o_underrun <= 1'b0;
            inp_rdy    <= 1'b1;
            hold       <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
        end else begin
            out_valid  <= 1'b0;
            o_underrun <= 1'b0;
            o_miso_oe  <= !cs_n_sync;
            o_miso     <= !cs_n_sync && tx_shift[p_WORD_LEN-1];

            // TX: a word start consumes the holding register; a host load in
            // the same cycle as a start on an empty register bypasses it.
            if (word_start) begin
                if (!inp_rdy) begin
                    tx_shift <= hold;
                    inp_rdy  <= 1'b1;
                end else if (inp_en) begin
                    tx_shift <= inp_data;
                end else begin
                    tx_shift   <= '0;
                    o_underrun <= 1'b1;
                end
            end else begin
                if (inp_en && inp_rdy) begin
                    hold    <= inp_data;
                    inp_rdy <= 1'b0;
                end
                if (cs_n_sync) begin
                    tx_shift <= '0;
                end else if (sclk_fall && bit_cnt != '0) begin
                    // bit_cnt==0 falls are skipped so the MSB loaded at a
                    // word boundary is still on MISO for the next rise.
                    tx_shift <= {tx_shift[p_WORD_LEN-2:0], 1'b0};
                end
            end

            // RX: deselect discards any partial word.
            if (cs_n_sync) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sclk_rise) begin
                rx_shift <= rx_next;
                if (bit_cnt == c_LAST) begin
                    bit_cnt   <= '0;
                    out_data  <= rx_next;
                    out_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave driven by a mode-0 master model
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk, mosi, cs_n;
    logic         miso, miso_oe;
    logic [W-1:0] inp_data;
    logic         inp_en, inp_rdy;
    logic [W-1:0] out_data;
    logic         out_valid, underrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ur_seen   = 0;
    int ur_exp    = 0;
    logic [W-1:0] rx_q[$];

    always #5 clk = ~clk;

    spi_slave #(.p_WORD_LEN(W), .p_SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .i_cs_n     (cs_n),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .inp_data   (inp_data),
        .inp_en     (inp_en),
        .inp_rdy    (inp_rdy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .o_underrun (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every out_valid pops the next expected RX word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (rx_q.size() == 0) chk("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
                else chk("out_data", {24'd0, out_data}, {24'd0, rx_q.pop_front()});
            end
            if (underrun === 1'b1) ur_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_load(input logic [W-1:0] d);
        int t = 0;
        while (inp_rdy !== 1'b1 && t < 50) begin
            cyc(1);
            t++;
        end
        chk("load_rdy_wait", {31'd0, inp_rdy}, 32'd1);
        inp_data = d;
        inp_en   = 1'b1;
        cyc(1);
        inp_en   = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high();
        cyc(HALF);
        cs_n = 1'b1;
        cyc(12);
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled at the rising edge.
    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] exp_miso,
                        input int nbits, input string name);
        logic [W-1:0] got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[W-1-i];
            cyc(HALF);
            got  = {got[W-2:0], miso};
            sclk = 1'b1;
            cyc(HALF);
            sclk = 1'b0;
        end
        if (nbits == W) chk(name, {24'd0, got}, {24'd0, exp_miso});
    endtask

    initial begin
        rst_n    = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cs_n     = 1'b1;
        inp_en   = 1'b0;
        inp_data = '0;
        cyc(3);
        chk("rst_miso_oe",   {31'd0, miso_oe},   32'd0);
        chk("rst_miso",      {31'd0, miso},      32'd0);
        chk("rst_inp_rdy",   {31'd0, inp_rdy},   32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_underrun",  {31'd0, underrun},  32'd0);
        rst_n = 1'b1;

        // Idle with CS high.
        cyc(20);
        chk("idle_miso_oe",  {31'd0, miso_oe}, 32'd0);
        chk("idle_inp_rdy",  {31'd0, inp_rdy}, 32'd1);
        chk("idle_underrun", ur_seen, ur_exp);

        // Single word: reply 0xA5, receive 0x3C. Word end finds holding empty.
        host_load(8'hA5);
        chk("t2_rdy_after_load", {31'd0, inp_rdy}, 32'd0);
        cs_low();
        chk("t2_rdy_after_cs_fall", {31'd0, inp_rdy}, 32'd1);
        chk("t2_miso_oe", {31'd0, miso_oe}, 32'd1);
        rx_q.push_back(8'h3C);
        xfer(8'h3C, 8'hA5, W, "t2_miso_word");
        cs_high();
        ur_exp += 1;
        chk("t2_underrun", ur_seen, ur_exp);
        chk("t2_out_data_held", {24'd0, out_data}, 32'h3C);

        // Back-to-back words with CS held low.
        host_load(8'h11);
        cs_low();
        host_load(8'h22);
        rx_q.push_back(8'hF0);
        xfer(8'hF0, 8'h11, W, "t3_miso_word1");
        rx_q.push_back(8'h0F);
        xfer(8'h0F, 8'h22, W, "t3_miso_word2");
        cs_high();
        ur_exp += 1;
        chk("t3_underrun", ur_seen, ur_exp);

        // No TX load before cs_fall: underrun at start, master reads zero.
        cs_low();
        ur_exp += 1;
        chk("t4_underrun_at_cs_fall", ur_seen, ur_exp);
        host_load(8'h77);
        rx_q.push_back(8'h96);
        xfer(8'h96, 8'h00, W, "t4_miso_zero");
        cs_high();
        chk("t4_underrun_total", ur_seen, ur_exp);

        // Aborted word after 5 rises, then a full word on a fresh count.
        cs_low();
        ur_exp += 1;
        xfer(8'hFF, 8'h00, 5, "t5_partial");
        cs_high();
        host_load(8'hC3);
        cs_low();
        rx_q.push_back(8'h81);
        xfer(8'h81, 8'hC3, W, "t5_miso_word");
        cs_high();
        ur_exp += 1;
        chk("t5_underrun", ur_seen, ur_exp);
        chk("t5_out_data", {24'd0, out_data}, 32'h81);

        // Asynchronous reset at bit 3 of a word.
        host_load(8'h96);
        cs_low();
        xfer(8'hA0, 8'h00, 3, "t6_partial");
        chk("t6_oe_before_reset",  {31'd0, miso_oe}, 32'd1);
        chk("t6_rdy_before_reset", {31'd0, inp_rdy}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_miso_oe",  {31'd0, miso_oe},  32'd0);
        chk("t6_async_miso",     {31'd0, miso},     32'd0);
        chk("t6_async_out_data", {24'd0, out_data}, 32'd0);
        chk("t6_async_inp_rdy",  {31'd0, inp_rdy},  32'd1);
        cs_n = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(4);
        host_load(8'hE7);
        cs_low();
        rx_q.push_back(8'h5A);
        xfer(8'h5A, 8'hE7, W, "t6_miso_word");
        cs_high();
        ur_exp += 1;
        chk("t6_underrun", ur_seen, ur_exp);

        cyc(20);
        chk("rx_queue_drained", rx_q.size(), 0);
        chk("underrun_total", ur_seen, 6);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
